mux_3_to_1_loader: RTL and testbench
====================================

Name: mux_3_to_1_loader

Overview:
- Merges the IFM, weight and bias load streams into one 32-bit bus.
- Each output beat carries a 2-bit destination tag `sel`: IFM=2'b01, WGT=2'b10, BIAS=2'b11, idle=2'b00.
- This is the transmit side feeding DEMUX_1_TO_3, which routes each beat by `sel`.
- Round-robin arbitration with bounded bursts keeps any one stream from starving the others.

Parameters:
- DATA_WIDTH, 32, width of every data path.
- BURST_LEN, 8, max beats one channel transfers per grant (>=1).
- IFM, 2'b01, tag for channel 0.
- WGT, 2'b10, tag for channel 1.
- BIAS, 2'b11, tag for channel 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifm_data  in  DATA_WIDTH  channel 0 data.
- wgt_data  in  DATA_WIDTH  channel 1 data.
- bias_data  in  DATA_WIDTH  channel 2 data.
- in_valid  in  3  per-channel valid; bit0=IFM, bit1=WGT, bit2=BIAS.
- in_ready  out  3  per-channel ready, combinational.
- out_ready  in  1  downstream accept.
- out_valid  out  1  registered output beat valid.
- sel  out  2  registered destination tag; 2'b00 when no beat.
- main_output  out  DATA_WIDTH  registered output data.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - state=IDLE, grant=0, beat count=0, rr pointer=0 (IFM).
  - out_valid=0, sel=2'b00, main_output=0.
  - in_ready=3'b000.
- Transfer rules:
  - Input transfer on channel c = in_valid[c] & in_ready[c] at a rising edge.
  - Output transfer = out_valid & out_ready.
  - can_load = !out_valid | out_ready.
- FSM IDLE:
  - in_ready=0.
  - If any in_valid is set, pick the first requesting channel scanning from the rr pointer upward, mod 3. Latch it as grant, clear the beat count, go to BURST.
  - Otherwise stay in IDLE.
  - Arbitration costs exactly one cycle; no data moves in IDLE.
- FSM BURST:
  - in_ready[grant] = can_load; all other in_ready bits are 0.
  - On an input transfer: main_output<=granted data, sel<=tag(grant), out_valid<=1, count<=count+1.
  - Exit to IDLE when the transfer makes count reach BURST_LEN, or when in_valid[grant]=0 at an edge with can_load=1.
  - On exit, rr pointer <= (grant+1) mod 3.
  - If in_valid[grant]=0 while can_load=0, stay in BURST; no timeout.
- Output register:
  - If out_ready=1 and there is no new input transfer, set out_valid<=0 and sel<=2'b00. main_output holds its last value.
  - If out_valid=1 and out_ready=0, sel, main_output and out_valid all hold (stall). No beat is dropped or duplicated.
- Latency: a beat accepted at edge N appears on main_output/sel after edge N (1 cycle).
- With out_ready held high, throughput in BURST is 1 beat/cycle. Each grant adds 1 idle arbitration cycle.
- Fairness: within one rotation each requesting channel gets at most BURST_LEN beats before the next requester is served.
- Simultaneous requests: the rr pointer decides; at reset the order is IFM, then WGT, then BIAS.
- in_valid deasserting mid-burst ends the burst early. The pointer still advances.
- Reset mid-burst: outputs clear immediately and asynchronously. The partial burst is discarded; the upstream re-sends.
- sel is never 2'b00 while out_valid=1, and never nonzero while out_valid=0.
- The count is wide enough for BURST_LEN, i.e. $clog2(BURST_LEN+1) bits.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, sel=00, main_output=0, in_ready=000. Assert rst_n=0 asynchronously mid-burst -> outputs clear before the next clock edge.
- Single stream: in_valid=001, ifm_data=15,16,17, out_ready=1 -> after 1 IDLE cycle, main_output=15,16,17 on consecutive cycles with sel=01 each; then out_valid=0, sel=00.
- Round-robin: in_valid=111, BURST_LEN=2, data IFM=15, WGT=40, BIAS=90 -> sel sequence 01,01,-,10,10,-,11,11,-,01 (`-` is an idle cycle with sel=00).
- Back-pressure: in WGT burst with out_ready=0 for 3 cycles -> sel=10 and main_output=40 held; in_ready=000; after release the next beat follows with no loss or repeat.
- Early termination: BIAS burst, in_valid[2] drops after 1 beat of 90 -> return to IDLE; pointer=IFM; a pending IFM request is granted next.
- Burst cap: IFM continuously valid with values 0..19, BURST_LEN=8, WGT valid -> exactly 8 IFM beats (0..7), then WGT is served, then IFM resumes at 8.

Source files
------------

// File: rtl/mux_3_to_1_loader.sv
// Merges the IFM, weight and bias load streams onto one tagged output bus.
// Round-robin arbitration with bursts capped at BURST_LEN beats per grant.
module mux_3_to_1_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 8,
    parameter logic [1:0]  IFM        = 2'b01,
    parameter logic [1:0]  WGT        = 2'b10,
    parameter logic [1:0]  BIAS       = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ifm_data,
    input  logic [DATA_WIDTH-1:0] wgt_data,
    input  logic [DATA_WIDTH-1:0] bias_data,
    input  logic [2:0]            in_valid,
    output logic [2:0]            in_ready,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [1:0]            sel,
    output logic [DATA_WIDTH-1:0] main_output
);

    localparam int unsigned CountWidth = $clog2(BURST_LEN + 1);
    localparam logic [CountWidth-1:0] BurstMax = CountWidth'(BURST_LEN);

    typedef enum logic {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic [1:0]              rr_q, rr_d;
    logic [CountWidth-1:0]   count_q, count_d;
    logic [CountWidth-1:0]   count_inc;
    logic                    out_valid_q;
    logic [1:0]              sel_q;
    logic [DATA_WIDTH-1:0]   data_q;

    logic                    can_load;
    logic                    take;
    logic [1:0]              cand0, cand1, cand2;
    logic [1:0]              grant_tag;
    logic [DATA_WIDTH-1:0]   grant_data;

    function automatic logic [1:0] next_ch(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    assign can_load  = !out_valid_q || out_ready;
    assign count_inc = count_q + CountWidth'(1);

    // Scan order for arbitration starts at the round-robin pointer.
    assign cand0 = rr_q;
    assign cand1 = next_ch(cand0);
    assign cand2 = next_ch(cand1);

    always_comb begin
        grant_tag  = IFM;
        grant_data = ifm_data;
        case (grant_q)
            2'd1: begin
                grant_tag  = WGT;
                grant_data = wgt_data;
            end
            2'd2: begin
                grant_tag  = BIAS;
                grant_data = bias_data;
            end
            default: begin
                grant_tag  = IFM;
                grant_data = ifm_data;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        count_d  = count_q;
        rr_d     = rr_q;
        in_ready = 3'b000;
        take     = 1'b0;
        case (state_q)
            StIdle: begin
                if (|in_valid) begin
                    state_d = StBurst;
                    count_d = '0;
                    if (in_valid[cand0]) begin
                        grant_d = cand0;
                    end else if (in_valid[cand1]) begin
                        grant_d = cand1;
                    end else begin
                        grant_d = cand2;
                    end
                end
            end
            StBurst: begin
                in_ready[grant_q] = can_load;
                take              = in_valid[grant_q] && can_load;
                if (take) begin
                    count_d = count_inc;
                end
                // A stalled output with a dropped valid keeps the grant; no timeout.
                if ((take && (count_inc == BurstMax)) || (can_load && !in_valid[grant_q])) begin
                    state_d = StIdle;
                    rr_d    = next_ch(grant_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 2'd0;
            rr_q    <= 2'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sel_q       <= 2'b00;
            data_q      <= '0;
        end else if (take) begin
            out_valid_q <= 1'b1;
            sel_q       <= grant_tag;
            data_q      <= grant_data;
        end else if (out_ready) begin
            // Data is left as-is once the beat is consumed; only the tag clears.
            out_valid_q <= 1'b0;
            sel_q       <= 2'b00;
        end
    end

    assign out_valid   = out_valid_q;
    assign sel         = sel_q;
    assign main_output = data_q;

endmodule

// File: tb/tb_mux_3_to_1_loader.sv
// Bench for mux_3_to_1_loader: directed scenarios on BURST_LEN=8 and BURST_LEN=2 instances,
// then randomized traffic against a beat-level reference model.
module tb_mux_3_to_1_loader;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] ifm_data = '0;
    logic [DW-1:0] wgt_data = '0;
    logic [DW-1:0] bias_data = '0;
    logic [2:0]    in_valid = 3'b000;
    logic          out_ready = 1'b0;

    logic [2:0]    rdy8, rdy2;
    logic          ov8, ov2;
    logic [1:0]    sel8, sel2;
    logic [DW-1:0] mo8, mo2;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = BURST_LEN 8 instance, 1 = BURST_LEN 2 instance.
    int            m_busy[2];
    int            m_grant[2];
    int            m_cnt[2];
    int            m_rr[2];
    int            m_ov[2];
    int            m_sel[2];
    logic [DW-1:0] m_data[2];
    int            m_bl[2] = '{8, 2};

    always #5 clk = ~clk;

    mux_3_to_1_loader #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (8)
    ) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifm_data    (ifm_data),
        .wgt_data    (wgt_data),
        .bias_data   (bias_data),
        .in_valid    (in_valid),
        .in_ready    (rdy8),
        .out_ready   (out_ready),
        .out_valid   (ov8),
        .sel         (sel8),
        .main_output (mo8)
    );

    mux_3_to_1_loader #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (2)
    ) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifm_data    (ifm_data),
        .wgt_data    (wgt_data),
        .bias_data   (bias_data),
        .in_valid    (in_valid),
        .in_ready    (rdy2),
        .out_ready   (out_ready),
        .out_valid   (ov2),
        .sel         (sel2),
        .main_output (mo2)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = 0;
            m_grant[k] = 0;
            m_cnt[k]   = 0;
            m_rr[k]    = 0;
            m_ov[k]    = 0;
            m_sel[k]   = 0;
            m_data[k]  = '0;
        end
    endtask

    // Advance model k by one clock edge using the currently driven inputs.
    task automatic model_step(input int k);
        logic [DW-1:0] d[3];
        bit can;
        bit took;
        bit found;
        int g;
        d[0]  = ifm_data;
        d[1]  = wgt_data;
        d[2]  = bias_data;
        can   = (m_ov[k] == 0) || out_ready;
        took  = 1'b0;
        found = 1'b0;
        if (m_busy[k] == 0) begin
            if (in_valid != 3'b000) begin
                for (int i = 0; i < 3; i++) begin
                    int c;
                    c = (m_rr[k] + i) % 3;
                    if (!found && in_valid[c]) begin
                        m_grant[k] = c;
                        found = 1'b1;
                    end
                end
                m_busy[k] = 1;
                m_cnt[k]  = 0;
            end
        end else begin
            g = m_grant[k];
            if (in_valid[g] && can) begin
                took      = 1'b1;
                m_ov[k]   = 1;
                m_sel[k]  = g + 1;
                m_data[k] = d[g];
                m_cnt[k]  = m_cnt[k] + 1;
                if (m_cnt[k] == m_bl[k]) begin
                    m_busy[k] = 0;
                    m_rr[k]   = (g + 1) % 3;
                end
            end else if (can && !in_valid[g]) begin
                m_busy[k] = 0;
                m_rr[k]   = (g + 1) % 3;
            end
        end
        if (!took && out_ready) begin
            m_ov[k]  = 0;
            m_sel[k] = 0;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 3'b000;
        out_ready = 1'b0;
        ifm_data  = '0;
        wgt_data  = '0;
        bias_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        ifm_data  = $urandom;
        wgt_data  = $urandom;
        bias_data = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_ov8 got %b want 0", ov8); end
        checks++; if (sel8 !== 2'b00) begin errors++; $display("FAIL reset_sel8 got %b want 00", sel8); end
        checks++; if (mo8 !== '0) begin errors++; $display("FAIL reset_mo8 got %h want 0", mo8); end
        checks++; if (rdy8 !== 3'b000) begin errors++; $display("FAIL reset_rdy8 got %b want 000", rdy8); end
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_ov2 got %b want 0", ov2); end
        checks++; if (sel2 !== 2'b00) begin errors++; $display("FAIL reset_sel2 got %b want 00", sel2); end
        checks++; if (mo2 !== '0) begin errors++; $display("FAIL reset_mo2 got %h want 0", mo2); end
        checks++; if (rdy2 !== 3'b000) begin errors++; $display("FAIL reset_rdy2 got %b want 000", rdy2); end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 3'b111;
        ifm_data  = 32'd5;
        wgt_data  = 32'd6;
        bias_data = 32'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ov8 !== 1'b1 || mo8 !== 32'd5) begin
            errors++; $display("FAIL async_pre got ov=%b data=%0d want ov=1 data=5", ov8, mo8);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (ov8 !== 1'b0 || sel8 !== 2'b00 || mo8 !== '0 || rdy8 !== 3'b000) begin
            errors++;
            $display("FAIL async_clear8 got ov=%b sel=%b data=%h rdy=%b want 0/00/0/000",
                     ov8, sel8, mo8, rdy8);
        end
        checks++; if (ov2 !== 1'b0 || sel2 !== 2'b00 || mo2 !== '0 || rdy2 !== 3'b000) begin
            errors++;
            $display("FAIL async_clear2 got ov=%b sel=%b data=%h rdy=%b want 0/00/0/000",
                     ov2, sel2, mo2, rdy2);
        end
        in_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 3'b001;
        ifm_data  = 32'd15;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL single_idle got ov=%b want 0", ov8); end
        checks++; if (rdy8 !== 3'b001) begin errors++; $display("FAIL single_rdy got %b want 001", rdy8); end
        for (int i = 0; i < 3; i++) begin
            ifm_data = 32'(15 + i);
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++; if (ov8 !== 1'b1 || sel8 !== 2'b01 || mo8 !== 32'(15 + i)) begin
                errors++;
                $display("FAIL single_beat%0d got ov=%b sel=%b data=%0d want 1/01/%0d",
                         i, ov8, sel8, mo8, 15 + i);
            end
        end
        in_valid = 3'b000;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ov8 !== 1'b0 || sel8 !== 2'b00 || mo8 !== 32'd17 || rdy8 !== 3'b000) begin
            errors++;
            $display("FAIL single_end got ov=%b sel=%b data=%0d rdy=%b want 0/00/17/000",
                     ov8, sel8, mo8, rdy8);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel[10];
        int exp_data;
        exp_sel = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1};
        do_reset();
        out_ready = 1'b1;
        in_valid  = 3'b111;
        ifm_data  = 32'd15;
        wgt_data  = 32'd40;
        bias_data = 32'd90;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++; if (sel2 !== exp_sel[k] || ov2 !== (exp_sel[k] != 2'd0)) begin
                errors++;
                $display("FAIL rr_sel%0d got sel=%b ov=%b want sel=%b", k, sel2, ov2, exp_sel[k]);
            end
            if (exp_sel[k] != 2'd0) begin
                exp_data = (exp_sel[k] == 2'd1) ? 15 : (exp_sel[k] == 2'd2) ? 40 : 90;
                checks++; if (mo2 !== 32'(exp_data)) begin
                    errors++; $display("FAIL rr_data%0d got %0d want %0d", k, mo2, exp_data);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 3'b010;
        wgt_data  = 32'd40;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ov8 !== 1'b1 || sel8 !== 2'b10 || mo8 !== 32'd40 || rdy8 !== 3'b000) begin
            errors++;
            $display("FAIL bp_first got ov=%b sel=%b data=%0d rdy=%b want 1/10/40/000",
                     ov8, sel8, mo8, rdy8);
        end
        wgt_data = 32'd41;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++; if (ov8 !== 1'b1 || sel8 !== 2'b10 || mo8 !== 32'd40 || rdy8 !== 3'b000) begin
                errors++;
                $display("FAIL bp_hold%0d got ov=%b sel=%b data=%0d rdy=%b want 1/10/40/000",
                         i, ov8, sel8, mo8, rdy8);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (rdy8 !== 3'b010) begin errors++; $display("FAIL bp_release_rdy got %b want 010", rdy8); end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ov8 !== 1'b1 || sel8 !== 2'b10 || mo8 !== 32'd41) begin
            errors++;
            $display("FAIL bp_next got ov=%b sel=%b data=%0d want 1/10/41", ov8, sel8, mo8);
        end
        in_valid = 3'b000;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ov8 !== 1'b0 || sel8 !== 2'b00) begin
            errors++; $display("FAIL bp_drain got ov=%b sel=%b want 0/00", ov8, sel8);
        end
    endtask

    task automatic test_early_term();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 3'b100;
        bias_data = 32'd90;
        ifm_data  = 32'd15;
        wgt_data  = 32'd40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ov8 !== 1'b1 || sel8 !== 2'b11 || mo8 !== 32'd90) begin
            errors++; $display("FAIL early_bias got ov=%b sel=%b data=%0d want 1/11/90", ov8, sel8, mo8);
        end
        in_valid = 3'b011;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ov8 !== 1'b0 || sel8 !== 2'b00 || rdy8 !== 3'b000) begin
            errors++;
            $display("FAIL early_idle got ov=%b sel=%b rdy=%b want 0/00/000", ov8, sel8, rdy8);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ov8 !== 1'b1 || sel8 !== 2'b01 || mo8 !== 32'd15) begin
            errors++; $display("FAIL early_next got ov=%b sel=%b data=%0d want 1/01/15", ov8, sel8, mo8);
        end
    endtask

    task automatic test_burst_cap();
        int ifm_idx;
        logic [1:0] exp_tag;
        int exp_data;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 3'b011;
        wgt_data  = 32'd40;
        ifm_idx   = 0;
        ifm_data  = 32'd0;
        @(posedge clk);
        for (int k = 0; k < 19; k++) begin
            if (k < 8) begin
                exp_tag = 2'b01; exp_data = k;
            end else if (k == 8 || k == 17) begin
                exp_tag = 2'b00; exp_data = 0;
            end else if (k < 17) begin
                exp_tag = 2'b10; exp_data = 40;
            end else begin
                exp_tag = 2'b01; exp_data = 8;
            end
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++; if (sel8 !== exp_tag) begin
                errors++; $display("FAIL cap_sel%0d got %b want %b", k, sel8, exp_tag);
            end
            if (exp_tag != 2'b00) begin
                checks++; if (mo8 !== 32'(exp_data)) begin
                    errors++; $display("FAIL cap_data%0d got %0d want %0d", k, mo8, exp_data);
                end
            end
            if (exp_tag == 2'b01) ifm_idx++;
            ifm_data = 32'(ifm_idx);
        end
    endtask

    task automatic test_random();
        logic [2:0]    a_rdy, e_rdy;
        logic          a_ov;
        logic [1:0]    a_sel;
        logic [DW-1:0] a_mo;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) in_valid[j] = ($urandom_range(0, 9) < 8);
            ifm_data  = $urandom;
            wgt_data  = $urandom;
            bias_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                a_rdy = (k == 0) ? rdy8 : rdy2;
                a_ov  = (k == 0) ? ov8 : ov2;
                a_sel = (k == 0) ? sel8 : sel2;
                a_mo  = (k == 0) ? mo8 : mo2;
                e_rdy = 3'b000;
                if (m_busy[k] != 0 && (m_ov[k] == 0 || out_ready)) e_rdy[m_grant[k]] = 1'b1;
                checks++; if (a_rdy !== e_rdy) begin
                    errors++; $display("FAIL rand_rdy k=%0d cyc=%0d got %b want %b", k, cyc, a_rdy, e_rdy);
                end
                checks++; if (a_ov !== (m_ov[k] != 0) || a_sel !== 2'(m_sel[k])) begin
                    errors++;
                    $display("FAIL rand_out k=%0d cyc=%0d got ov=%b sel=%b want ov=%0d sel=%0d",
                             k, cyc, a_ov, a_sel, m_ov[k], m_sel[k]);
                end
                if (m_ov[k] != 0) begin
                    checks++; if (a_mo !== m_data[k]) begin
                        errors++;
                        $display("FAIL rand_data k=%0d cyc=%0d got %h want %h", k, cyc, a_mo, m_data[k]);
                    end
                end
            end
            model_step(0);
            model_step(1);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_async_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_early_term();
        test_burst_cap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
